// File: rtl/ppu_pkg.sv
// ppu_pkg: shared DMA FSM states, OAM/DMA address constants and echo-page remap
package ppu_pkg;
    typedef enum logic [1:0] {IDLE, READ, WRITE} dma_state_t;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_END      = 16'hFE9F;
    localparam logic [7:0]  ECHO_PAGE    = 8'hE0;
    function automatic logic [7:0] eff_page(input logic [7:0] p);
        return p >= ECHO_PAGE ? p - 8'h20 : p;
    endfunction
endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: FF46-triggered OAM DMA sequencer plus DMA > PPU > CPU OAM bus arbiter
// ports: clk/rst (async active-high); mmio_a/mmio_din/mmio_wr/mmio_dout CPU side;
// src_a/src_rd/src_dout DMA source bus; ppu_oam_req/ppu_oam_a PPU request;
// oam_a/oam_din/oam_wr/oam_dout arbitrated OAM bus; dma_active transfer flag
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter int          OAM_BYTES = 160,
    parameter logic [15:0] OAM_BASE  = ppu_pkg::OAM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_a,
    input  logic [7:0]  mmio_din,
    input  logic        mmio_wr,
    output logic [7:0]  mmio_dout,
    output logic [15:0] src_a,
    output logic        src_rd,
    input  logic [7:0]  src_dout,
    input  logic        ppu_oam_req,
    input  logic [15:0] ppu_oam_a,
    output logic [15:0] oam_a,
    output logic [7:0]  oam_din,
    output logic        oam_wr,
    input  logic [7:0]  oam_dout,
    output logic        dma_active
);
    localparam logic [15:0] OAM_LAST = OAM_BASE + 16'(OAM_BYTES - 1);
    dma_state_t  r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic        r_dma_active;
    logic        r_src_rd;
    logic [15:0] r_src_a;
    logic        w_reg_wr;
    logic        w_last;
    logic [7:0]  w_idx_nx;
    logic        w_cpu_oam;
    logic        w_cpu_grant;
    logic [15:0] w_dma_a;
    assign w_reg_wr    = mmio_wr && mmio_a == DMA_REG_ADDR;
    assign w_last      = r_idx == 8'(OAM_BYTES - 1);
    assign w_idx_nx    = r_idx + 8'd1;
    assign w_cpu_oam   = mmio_a >= OAM_BASE && mmio_a <= OAM_LAST;
    assign w_cpu_grant = w_cpu_oam && !r_dma_active && !ppu_oam_req;
    assign w_dma_a     = OAM_BASE + {8'h00, r_idx};
    // src outputs are registered one step ahead so they line up with the READ state
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state      <= IDLE;
            r_page       <= 8'h00;
            r_idx        <= 8'h00;
            r_dma_active <= 1'b0;
            r_src_rd     <= 1'b0;
            r_src_a      <= 16'h0000;
        end else if (w_reg_wr) begin
            r_state      <= READ;
            r_page       <= mmio_din;
            r_idx        <= 8'h00;
            r_dma_active <= 1'b1;
            r_src_rd     <= 1'b1;
            r_src_a      <= {eff_page(mmio_din), 8'h00};
        end else if (r_state == READ) begin
            r_state  <= WRITE;
            r_src_rd <= 1'b0;
        end else if (r_state == WRITE) begin
            r_state      <= w_last ? IDLE : READ;
            r_idx        <= w_last ? r_idx : w_idx_nx;
            r_dma_active <= !w_last;
            r_src_rd     <= !w_last;
            r_src_a      <= w_last ? r_src_a : {eff_page(r_page), w_idx_nx};
        end
    assign dma_active = r_dma_active;
    assign src_rd     = r_src_rd;
    assign src_a      = r_src_a;
    // during DMA the PPU sees whatever byte the DMA is addressing
    assign oam_a   = r_dma_active ? w_dma_a : ppu_oam_req ? ppu_oam_a : w_cpu_oam ? mmio_a : 16'hFFFF;
    assign oam_wr  = r_dma_active ? r_state == WRITE : w_cpu_grant && mmio_wr;
    assign oam_din = r_dma_active ? src_dout : mmio_din;
    assign mmio_dout = mmio_wr ? 8'h00 :
                       mmio_a == DMA_REG_ADDR ? r_page :
                       !w_cpu_oam ? 8'h00 :
                       w_cpu_grant ? oam_dout : 8'hFF;
endmodule
